gemm_job_sequencer: RTL and testbench

GEMM_JOB_SEQUENCER -- requirements
Module: gemm_job_sequencer

---
 rtl/gemm_job_sequencer.sv | 203 ++++++++++++++++++++
 tb/tb_gemm_job_sequencer.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/gemm_job_sequencer.sv
// GEMM job sequencer: turns one host job into FETCH/FETCH_LEN/DISP/TILE commands.
// Optional watchdog enabled with `define GEMM_SEQ_WATCHDOG_EN.
module gemm_job_sequencer #(
    parameter int CMD_W       = 32,
    parameter int MAX_TILES   = 255,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_job_valid,
    output logic             o_job_ready,
    input  logic [23:0]      i_left_addr,
    input  logic [23:0]      i_right_addr,
    input  logic [15:0]      i_fetch_len,
    input  logic [10:0]      i_disp_len,
    input  logic [7:0]       i_num_tiles,
    output logic [CMD_W-1:0] o_cmd_wdata,
    output logic             o_cmd_wen,
    input  logic             i_cmd_full,
    input  logic             i_tile_done,
    output logic             o_job_done,
    output logic             o_busy,
    output logic             o_err,
    output logic [1:0]       o_state,
    output logic [7:0]       o_tiles_done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [7:0] OP_FETCH = 8'h01;
    localparam logic [7:0] OP_DISP  = 8'h02;
    localparam logic [7:0] OP_TILE  = 8'h03;
    localparam logic [7:0] OP_FLEN  = 8'h04;
    localparam logic [8:0] MAX_T    = 9'(MAX_TILES);

    // Assert asynchronously, release on a clock edge
    logic [1:0] rst_sync;
    logic       rst_n;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n)
            rst_sync <= 2'b00;
        else
            rst_sync <= {rst_sync[0], 1'b1};
    end

    assign rst_n = rst_sync[1];

    state_t      state;
    logic [23:0] left_q;
    logic [23:0] right_q;
    logic [15:0] len_q;
    logic [10:0] disp_q;
    logic [7:0]  num_q;
    logic [8:0]  idx;

    logic       accept;
    logic       over_max;
    logic       in_job;
    logic       wr_now;
    logic       tile_ok;
    logic       tile_bad;
    logic       wd_fire;
    logic [8:0] last_idx;
    logic [7:0] tiles_next;

    assign accept     = i_job_valid && o_job_ready;
    assign over_max   = {1'b0, i_num_tiles} > MAX_T;
    assign in_job     = (state == ISSUE) || (state == WAIT);
    assign wr_now     = (state == ISSUE) && !i_cmd_full;
    assign last_idx   = {1'b0, num_q} + 9'd3;
    assign tile_ok    = i_tile_done && in_job && (o_tiles_done != num_q);
    assign tile_bad   = i_tile_done && !tile_ok;
    assign tiles_next = o_tiles_done + {7'd0, tile_ok};

    assign o_job_ready = rst_n && (state == IDLE);
    assign o_busy      = state != IDLE;
    assign o_state     = state;

    logic [7:0]       op;
    logic [23:0]      pl;
    logic [CMD_W-1:0] word;

    always_comb begin
        op = OP_TILE;
        pl = {16'h0, idx[7:0] - 8'd4};
        unique case (1'b1)
            idx == 9'd0: begin
                op = OP_FETCH;
                pl = left_q;
            end
            idx == 9'd1: begin
                op = OP_FETCH;
                pl = right_q;
            end
            idx == 9'd2: begin
                op = OP_FLEN;
                pl = {8'h0, len_q};
            end
            idx == 9'd3: begin
                op = OP_DISP;
                pl = {13'h0, disp_q};
            end
            default: ;
        endcase
        word              = '0;
        word[CMD_W-1 -: 8] = op;
        word[23:0]        = pl;
    end

`ifdef GEMM_SEQ_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
    logic [WD_W-1:0] wd_cnt;

    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n)
            wd_cnt <= '0;
        else if (!in_job || wr_now || i_tile_done)
            wd_cnt <= '0;
        else
            wd_cnt <= wd_cnt + 1'b1;
    end

    assign wd_fire = in_job && !wr_now && !i_tile_done &&
                     (wd_cnt == WD_W'(TIMEOUT_CYC - 1));
`else
    assign wd_fire = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            left_q       <= '0;
            right_q      <= '0;
            len_q        <= '0;
            disp_q       <= '0;
            num_q        <= '0;
            idx          <= '0;
            o_cmd_wdata  <= '0;
            o_cmd_wen    <= 1'b0;
            o_job_done   <= 1'b0;
            o_err        <= 1'b0;
            o_tiles_done <= '0;
        end else begin
            o_cmd_wen  <= 1'b0;
            o_job_done <= 1'b0;
            if (tile_bad)
                o_err <= 1'b1;
            if (tile_ok)
                o_tiles_done <= tiles_next;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        left_q       <= i_left_addr;
                        right_q      <= i_right_addr;
                        len_q        <= i_fetch_len;
                        disp_q       <= i_disp_len;
                        num_q        <= over_max ? MAX_T[7:0] : i_num_tiles;
                        idx          <= '0;
                        o_tiles_done <= '0;
                        if (over_max)
                            o_err <= 1'b1;
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (wr_now) begin
                        o_cmd_wen   <= 1'b1;
                        o_cmd_wdata <= word;
                        idx         <= idx + 9'd1;
                        if (idx == last_idx) begin
                            if (num_q == 8'd0) begin
                                state      <= DONE;
                                o_job_done <= 1'b1;
                            end else begin
                                state <= WAIT;
                            end
                        end
                    end
                end
                WAIT: begin
                    if (tiles_next == num_q) begin
                        state      <= DONE;
                        o_job_done <= 1'b1;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
            if (wd_fire) begin
                o_err      <= 1'b1;
                o_job_done <= 1'b1;
                state      <= DONE;
            end
        end
    end

endmodule

// File: tb/tb_gemm_job_sequencer.sv
// Directed bench for gemm_job_sequencer.
// Build with GEMM_SEQ_WATCHDOG_EN defined to also cover the watchdog.
module tb_gemm_job_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        job_valid = 1'b0;
    logic        job_ready;
    logic [23:0] left_addr = '0;
    logic [23:0] right_addr = '0;
    logic [15:0] fetch_len = '0;
    logic [10:0] disp_len = '0;
    logic [7:0]  num_tiles = '0;
    logic [31:0] cmd_wdata;
    logic        cmd_wen;
    logic        cmd_full = 1'b0;
    logic        tile_done = 1'b0;
    logic        job_done;
    logic        busy;
    logic        err;
    logic [1:0]  state;
    logic [7:0]  tiles_done;

    gemm_job_sequencer #(
        .CMD_W      (32),
        .MAX_TILES  (4),
        .TIMEOUT_CYC(100)
    ) dut (
        .i_clk       (clk),
        .i_reset_n   (rst_n),
        .i_job_valid (job_valid),
        .o_job_ready (job_ready),
        .i_left_addr (left_addr),
        .i_right_addr(right_addr),
        .i_fetch_len (fetch_len),
        .i_disp_len  (disp_len),
        .i_num_tiles (num_tiles),
        .o_cmd_wdata (cmd_wdata),
        .o_cmd_wen   (cmd_wen),
        .i_cmd_full  (cmd_full),
        .i_tile_done (tile_done),
        .o_job_done  (job_done),
        .o_busy      (busy),
        .o_err       (err),
        .o_state     (state),
        .o_tiles_done(tiles_done)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          failures = 0;
    int          ncyc = 0;
    int          done_cnt = 0;
    int          done_cyc = 0;
    logic [31:0] wq[$];
    int          wc[$];
    logic [31:0] exp1[6] = '{32'h01000100, 32'h01000200, 32'h04000010,
                             32'h02000010, 32'h03000000, 32'h03000001};
    logic [31:0] exp3[4] = '{32'h01ABCDEF, 32'h01123456, 32'h0400BEEF,
                             32'h020007FF};

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    initial forever begin
        @(negedge clk);
        ncyc++;
        if (cmd_wen) begin
            wq.push_back(cmd_wdata);
            wc.push_back(ncyc);
        end
        if (job_done) begin
            done_cnt++;
            done_cyc = ncyc;
        end
    end

    task automatic apply_reset();
        @(negedge clk);
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        wq.delete();
        wc.delete();
    endtask

    task automatic start_job(input logic [23:0] l, input logic [23:0] r,
                             input logic [15:0] len, input logic [10:0] d,
                             input logic [7:0] n, output int acc);
        wq.delete();
        wc.delete();
        @(negedge clk);
        #1;
        left_addr  = l;
        right_addr = r;
        fetch_len  = len;
        disp_len   = d;
        num_tiles  = n;
        job_valid  = 1'b1;
        acc        = ncyc;
        check("ready", 32'(job_ready), 32'd1);
        @(negedge clk);
        #1 job_valid = 1'b0;
    endtask

    task automatic wait_words(input int n);
        for (int i = 0; i < 100 && wq.size() < n; i++) begin
            @(negedge clk);
            #1;
        end
        repeat (3) @(negedge clk);
        #1;
        check("nwords", 32'(wq.size()), 32'(n));
    endtask

    task automatic tile_pulse(output int t);
        @(negedge clk);
        #1 tile_done = 1'b1;
        t = ncyc;
        @(negedge clk);
        #1 tile_done = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 50 && state != 2'd0; i++) begin
            @(negedge clk);
            #1;
        end
        check("idle", 32'(state), 32'd0);
    endtask

    initial begin
        int acc;
        int t1;
        int t2;
        int n0;

        apply_reset();
        check("rst_ready", 32'(job_ready), 32'd1);
        check("rst_state", 32'(state), 32'd0);
        check("rst_wen", 32'(cmd_wen), 32'd0);
        check("rst_wdata", cmd_wdata, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_tiles", 32'(tiles_done), 32'd0);
        check("rst_done", 32'(job_done), 32'd0);

        // Basic two-tile job, FIFO never full
        start_job(24'h000100, 24'h000200, 16'h0010, 11'd16, 8'd2, acc);
        wait_words(6);
        for (int i = 0; i < 6; i++)
            check($sformatf("t1_w%0d", i), wq[i], exp1[i]);
        check("t1_lat", 32'(wc[0] - acc), 32'd2);
        for (int i = 1; i < 6; i++)
            check($sformatf("t1_b2b%0d", i), 32'(wc[i] - wc[i-1]), 32'd1);
        check("t1_wait", 32'(state), 32'd2);
        check("t1_busy", 32'(busy), 32'd1);
        n0 = done_cnt;
        tile_pulse(t1);
        check("t1_tiles1", 32'(tiles_done), 32'd1);
        check("t1_nodone", 32'(done_cnt - n0), 32'd0);
        tile_pulse(t2);
        check("t1_donecnt", 32'(done_cnt - n0), 32'd1);
        check("t1_donelat", 32'(done_cyc - t2), 32'd1);
        check("t1_tiles2", 32'(tiles_done), 32'd2);
        wait_idle();
        check("t1_idlebusy", 32'(busy), 32'd0);

        // Same job with a 5-cycle full stall after word 2
        start_job(24'h000100, 24'h000200, 16'h0010, 11'd16, 8'd2, acc);
        for (int i = 0; i < 100 && wq.size() < 2; i++) begin
            @(negedge clk);
            #1;
        end
        cmd_full = 1'b1;
        repeat (5) @(negedge clk);
        #1 cmd_full = 1'b0;
        wait_words(6);
        for (int i = 0; i < 6; i++)
            check($sformatf("t2_w%0d", i), wq[i], exp1[i]);
        check("t2_gap", 32'(wc[2] - wc[1]), 32'd6);
        tile_pulse(t1);
        tile_pulse(t2);
        wait_idle();

        // Zero tiles: header words only, then done
        n0 = done_cnt;
        start_job(24'hABCDEF, 24'h123456, 16'hBEEF, 11'h7FF, 8'd0, acc);
        wait_words(4);
        for (int i = 0; i < 4; i++)
            check($sformatf("t3_w%0d", i), wq[i], exp3[i]);
        check("t3_donecnt", 32'(done_cnt - n0), 32'd1);
        check("t3_doneord", 32'(done_cyc >= wc[3]), 32'd1);
        check("t3_tiles", 32'(tiles_done), 32'd0);
        wait_idle();

        // Spurious completion in IDLE, error sticks through next job
        check("t4_err0", 32'(err), 32'd0);
        tile_pulse(t1);
        check("t4_err1", 32'(err), 32'd1);
        check("t4_tiles", 32'(tiles_done), 32'd0);
        start_job(24'h000010, 24'h000020, 16'h0004, 11'd4, 8'd1, acc);
        wait_words(5);
        check("t4_tile0", wq[4], 32'h03000000);
        tile_pulse(t1);
        wait_idle();
        check("t4_errkeep", 32'(err), 32'd1);
        check("t4_tilesd", 32'(tiles_done), 32'd1);

        // Reset in WAIT with one of three tiles done
        apply_reset();
        check("t5_errclr", 32'(err), 32'd0);
        start_job(24'h000300, 24'h000400, 16'h0020, 11'd8, 8'd3, acc);
        wait_words(7);
        tile_pulse(t1);
        check("t5_tiles1", 32'(tiles_done), 32'd1);
        check("t5_wait", 32'(state), 32'd2);
        n0 = wq.size();
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("t5_state", 32'(state), 32'd0);
        check("t5_wen", 32'(cmd_wen), 32'd0);
        check("t5_wdata", cmd_wdata, 32'd0);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_tiles", 32'(tiles_done), 32'd0);
        check("t5_done", 32'(job_done), 32'd0);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("t5_ready", 32'(job_ready), 32'd1);
        check("t5_nowr", 32'(wq.size()), 32'(n0));

        // Tile count above MAX_TILES=4 is clamped and flags an error
        check("t6_err0", 32'(err), 32'd0);
        start_job(24'h000500, 24'h000600, 16'h0008, 11'd2, 8'd6, acc);
        check("t6_err1", 32'(err), 32'd1);
        wait_words(8);
        check("t6_last", wq[7], 32'h03000003);
        for (int i = 0; i < 4; i++)
            tile_pulse(t1);
        wait_idle();
        check("t6_tiles", 32'(tiles_done), 32'd4);

`ifdef GEMM_SEQ_WATCHDOG_EN
        apply_reset();
        start_job(24'h000700, 24'h000800, 16'h0001, 11'd1, 8'd1, acc);
        wait_words(5);
        n0 = done_cnt;
        for (int i = 0; i < 200 && done_cnt == n0; i++) begin
            @(negedge clk);
            #1;
        end
        check("wd_donecnt", 32'(done_cnt - n0), 32'd1);
        check("wd_lat", 32'(done_cyc - wc[4]), 32'd100);
        check("wd_err", 32'(err), 32'd1);
        wait_idle();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
